// File: rtl/scpad_dram_res_seq_pkg.sv
// rtl/scpad_dram_res_seq_pkg.sv - shared types and constants for the DRAM response sequencer
package scpad_dram_res_seq_pkg;

  localparam int SCPAD_DRAM_TAGS   = 16;
  localparam int SCPAD_DRAM_ID_W   = 8;
  localparam int SCPAD_DRAM_BEAT_W = 64;
  localparam int SCPAD_DRAM_TAG_W  = $clog2(SCPAD_DRAM_TAGS);
  localparam int SCPAD_DRAM_CNT_W  = SCPAD_DRAM_TAG_W + 1;

  // Crossbar placement of one scratchpad row; also consumed by the write latch.
  typedef struct packed {
    logic [7:0] slot_mask;
    logic [2:0] shift;
    logic [7:0] valid_mask;
  } xbar_desc_t;

  typedef struct packed {
    logic       valid;
    xbar_desc_t xbar;
    logic [2:0] num_request;
    logic [2:0] beat_cnt;
  } scpad_dram_tag_entry_t;

  typedef logic [1:0] res_seq_state_t;
  localparam res_seq_state_t ST_IDLE  = 2'd0;
  localparam res_seq_state_t ST_FILL  = 2'd1;
  localparam res_seq_state_t ST_DRAIN = 2'd2;

  function automatic logic [SCPAD_DRAM_ID_W-1:0] tag_to_id(input logic [SCPAD_DRAM_TAG_W-1:0] tag);
    return SCPAD_DRAM_ID_W'(tag);
  endfunction

endpackage

// File: rtl/scpad_dram_res_seq_if.sv
// rtl/scpad_dram_res_seq_if.sv - issuer, DRAM response and latch-side signals of the sequencer
interface scpad_dram_res_seq_if;
  import scpad_dram_res_seq_pkg::*;

  logic                         issue_valid;
  logic                         issue_ready;
  xbar_desc_t                   issue_xbar;
  logic [2:0]                   issue_num_request;
  logic [SCPAD_DRAM_ID_W-1:0]   issue_id;

  logic                         dram_res_valid;
  logic [SCPAD_DRAM_ID_W-1:0]   dram_res_id;
  logic [SCPAD_DRAM_BEAT_W-1:0] dram_res_rddata;
  logic                         dram_res_ready;

  logic                         lat_dram_res_valid;
  logic [SCPAD_DRAM_ID_W-1:0]   lat_dram_id;
  xbar_desc_t                   lat_xbar;
  logic [2:0]                   lat_num_request;
  logic [SCPAD_DRAM_BEAT_W-1:0] lat_dram_rddata;

  logic                         sram_write_req_latched;
  logic                         be_stall;
  logic [SCPAD_DRAM_CNT_W-1:0]  outstanding;
  logic                         err_unknown_id;

  modport master (
    output issue_valid, issue_xbar, issue_num_request,
    output dram_res_valid, dram_res_id, dram_res_rddata,
    output sram_write_req_latched, be_stall,
    input  issue_ready, issue_id, dram_res_ready,
    input  lat_dram_res_valid, lat_dram_id, lat_xbar, lat_num_request, lat_dram_rddata,
    input  outstanding, err_unknown_id
  );

  modport slave (
    input  issue_valid, issue_xbar, issue_num_request,
    input  dram_res_valid, dram_res_id, dram_res_rddata,
    input  sram_write_req_latched, be_stall,
    output issue_ready, issue_id, dram_res_ready,
    output lat_dram_res_valid, lat_dram_id, lat_xbar, lat_num_request, lat_dram_rddata,
    output outstanding, err_unknown_id
  );

endinterface

// File: rtl/scpad_dram_res_seq_tag_alloc.sv
// rtl/scpad_dram_res_seq_tag_alloc.sv - lowest-free-index priority encoder over the tag valid vector
module scpad_dram_res_seq_tag_alloc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  output logic         any_free,
  output logic [W-1:0] idx
);

  // Scanning downwards lets the lowest free index be the last one written.
  always_comb begin
    any_free = 1'b0;
    idx      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        any_free = 1'b1;
        idx      = W'(i);
      end
    end
  end

endmodule

// File: rtl/scpad_dram_res_seq.sv
// rtl/scpad_dram_res_seq.sv - tags outstanding DRAM row fills and forwards their beats one row at a time
module scpad_dram_res_seq
  import scpad_dram_res_seq_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  scpad_dram_res_seq_if.slave  bus
);

  localparam int N  = SCPAD_DRAM_TAGS;
  localparam int TW = SCPAD_DRAM_TAG_W;
  localparam int IW = SCPAD_DRAM_ID_W;
  localparam int BW = SCPAD_DRAM_BEAT_W;
  localparam int CW = SCPAD_DRAM_CNT_W;

  scpad_dram_tag_entry_t tbl [N];
  logic [N-1:0]          valid_vec;

  logic           alive;
  res_seq_state_t state;
  logic [TW-1:0]  cur_tag;
  logic [CW-1:0]  outstanding_q;
  logic           err_q;

  logic           lat_valid_q;
  logic [IW-1:0]  lat_id_q;
  xbar_desc_t     lat_xbar_q;
  logic [2:0]     lat_num_q;
  logic [BW-1:0]  lat_data_q;

  logic                  any_free;
  logic [TW-1:0]         free_idx;
  logic [TW-1:0]         res_tag;
  logic                  res_in_range;
  logic                  res_hit;
  scpad_dram_tag_entry_t res_ent;
  logic                  issue_fire;
  logic                  res_fire;
  logic                  fwd;
  logic                  free_fire;

  for (genvar g = 0; g < N; g++) begin : g_valid
    assign valid_vec[g] = tbl[g].valid;
  end

  scpad_dram_res_seq_tag_alloc #(.N(N), .W(TW)) u_tag_alloc (
    .valid    (valid_vec),
    .any_free (any_free),
    .idx      (free_idx)
  );

  // Ids with non-zero upper bits can never name a table entry and are treated as unknown.
  assign res_tag      = bus.dram_res_id[TW-1:0];
  assign res_in_range = (bus.dram_res_id[IW-1:TW] == '0);
  assign res_ent      = tbl[res_tag];
  assign res_hit      = res_in_range & res_ent.valid;

  // alive holds every handshake output low until the cycle after reset is released.
  assign bus.issue_ready = alive & any_free;
  assign bus.issue_id    = alive ? tag_to_id(free_idx) : '0;

  always_comb begin
    bus.dram_res_ready = 1'b0;
    if (alive && !bus.be_stall) begin
      case (state)
        ST_IDLE: bus.dram_res_ready = 1'b1;
        ST_FILL: bus.dram_res_ready = (bus.dram_res_id == tag_to_id(cur_tag));
        default: bus.dram_res_ready = 1'b0;
      endcase
    end
  end

  assign issue_fire = bus.issue_valid & bus.issue_ready;
  assign res_fire   = bus.dram_res_valid & bus.dram_res_ready;
  assign fwd        = res_fire & res_hit;
  assign free_fire  = (state == ST_DRAIN) & bus.sram_write_req_latched;

  always_ff @(posedge CLK) begin
    if (RST) begin
      alive         <= 1'b0;
      state         <= ST_IDLE;
      cur_tag       <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      lat_valid_q   <= 1'b0;
      lat_id_q      <= '0;
      lat_xbar_q    <= '0;
      lat_num_q     <= '0;
      lat_data_q    <= '0;
      for (int i = 0; i < N; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      alive         <= 1'b1;
      lat_valid_q   <= 1'b0;
      outstanding_q <= outstanding_q + CW'(issue_fire) - CW'(free_fire);

      // The issued entry is free and the freed one is valid, so they never collide.
      if (issue_fire) begin
        tbl[free_idx] <= '{valid: 1'b1, xbar: bus.issue_xbar,
                           num_request: bus.issue_num_request, beat_cnt: 3'd0};
      end
      if (free_fire) begin
        tbl[cur_tag].valid <= 1'b0;
      end

      if (fwd) begin
        lat_valid_q <= 1'b1;
        lat_id_q    <= bus.dram_res_id;
        lat_xbar_q  <= res_ent.xbar;
        lat_num_q   <= res_ent.num_request;
        lat_data_q  <= bus.dram_res_rddata;
      end

      case (state)
        ST_IDLE: begin
          if (res_fire) begin
            if (res_hit) begin
              cur_tag <= res_tag;
              if (res_ent.num_request == 3'd0) begin
                state <= ST_DRAIN;
              end else begin
                state                  <= ST_FILL;
                tbl[res_tag].beat_cnt <= 3'd1;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (res_fire) begin
            if (res_ent.beat_cnt == res_ent.num_request) begin
              state <= ST_DRAIN;
            end else begin
              tbl[res_tag].beat_cnt <= res_ent.beat_cnt + 3'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.sram_write_req_latched) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.lat_dram_res_valid = lat_valid_q;
  assign bus.lat_dram_id        = lat_id_q;
  assign bus.lat_xbar           = lat_xbar_q;
  assign bus.lat_num_request    = lat_num_q;
  assign bus.lat_dram_rddata    = lat_data_q;
  assign bus.outstanding        = outstanding_q;
  assign bus.err_unknown_id     = err_q;

endmodule

// File: tb/tb_scpad_dram_res_seq.sv
// tb/tb_scpad_dram_res_seq.sv - vector table plus directed corner sequences for scpad_dram_res_seq
module tb_scpad_dram_res_seq;
  import scpad_dram_res_seq_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  scpad_dram_res_seq_if bus ();

  scpad_dram_res_seq dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic        iv;
    logic [2:0]  inum;
    logic        dv;
    logic [7:0]  did;
    logic [63:0] d;
    logic        lt;
    logic        e_ir;
    logic [7:0]  e_iid;
    logic        e_dr;
    logic        e_lv;
    logic [7:0]  e_lid;
    logic [2:0]  e_lnum;
    logic [63:0] e_ld;
    logic [4:0]  e_out;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic xbar_desc_t mk_xbar(input logic [2:0] n);
    xbar_desc_t x;
    x.slot_mask  = 8'h80 >> n;
    x.shift      = ~n;
    x.valid_mask = 8'hFF >> (3'd7 - n);
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_in(input logic iv, input logic [2:0] inum, input logic dv, input logic [7:0] did,
                        input logic [63:0] d, input logic lt, input logic st);
    bus.issue_valid            = iv;
    bus.issue_num_request      = inum;
    bus.issue_xbar             = mk_xbar(inum);
    bus.dram_res_valid         = dv;
    bus.dram_res_id            = did;
    bus.dram_res_rddata        = d;
    bus.sram_write_req_latched = lt;
    bus.be_stall               = st;
  endtask

  task automatic drive(input logic iv, input logic [2:0] inum, input logic dv, input logic [7:0] did,
                       input logic [63:0] d, input logic lt, input logic st);
    @(negedge CLK);
    set_in(iv, inum, dv, did, d, lt, st);
    #1;
  endtask

  task automatic add(input logic iv, input logic [2:0] inum, input logic dv, input logic [7:0] did,
                     input logic [63:0] d, input logic lt, input logic e_ir, input logic [7:0] e_iid,
                     input logic e_dr, input logic e_lv, input logic [7:0] e_lid, input logic [2:0] e_lnum,
                     input logic [63:0] e_ld, input logic [4:0] e_out);
    vec_t v;
    v = '{iv, inum, dv, did, d, lt, e_ir, e_iid, e_dr, e_lv, e_lid, e_lnum, e_ld, e_out};
    vecs.push_back(v);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " issue_ready"}, bus.issue_ready, 0);
    chk({tag, " issue_id"}, bus.issue_id, 0);
    chk({tag, " dram_res_ready"}, bus.dram_res_ready, 0);
    chk({tag, " lat_valid"}, bus.lat_dram_res_valid, 0);
    chk({tag, " lat_id"}, bus.lat_dram_id, 0);
    chk({tag, " lat_xbar"}, bus.lat_xbar, 0);
    chk({tag, " lat_num"}, bus.lat_num_request, 0);
    chk({tag, " lat_data"}, bus.lat_dram_rddata, 0);
    chk({tag, " outstanding"}, bus.outstanding, 0);
    chk({tag, " err"}, bus.err_unknown_id, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    RST = 1'b1;
    set_in(1, 0, 1, 0, 64'hDEAD, 1, 0);
    @(negedge CLK);
    #1;
    chk_zero_outputs(tag);
    RST = 1'b0;
    #1;
    chk({tag, " ready in release cycle"}, bus.issue_ready, 0);
    chk({tag, " dram ready in release cycle"}, bus.dram_res_ready, 0);
    @(negedge CLK);
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk({tag, " ready after release"}, bus.issue_ready, 1);
    chk({tag, " outstanding after release"}, bus.outstanding, 0);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);

    // single-beat row
    add(1,0, 0,0,0,0,                   1,0, 1, 0,0,0,0, 0);
    add(0,0, 1,0,64'hA5A5_A5A5_A5A5_A5A5,0, 1,1, 1, 0,0,0,0, 1);
    add(0,0, 0,0,0,0,                   1,1, 0, 1,0,0,64'hA5A5_A5A5_A5A5_A5A5, 1);
    add(0,0, 0,0,0,1,                   1,1, 0, 0,0,0,0, 1);
    add(0,0, 0,0,0,0,                   1,0, 1, 0,0,0,0, 0);
    // eight-beat row, back to back
    add(1,7, 0,0,0,0,                   1,0, 1, 0,0,0,0, 0);
    for (int b = 0; b < 8; b++)
      add(0,0, 1,0,64'h100 + b,0,       1,1, 1, (b > 0),0,7,64'h100 + b - 1, 1);
    add(0,0, 0,0,0,0,                   1,1, 0, 1,0,7,64'h107, 1);
    add(0,0, 0,0,0,1,                   1,1, 0, 0,0,0,0, 1);
    add(0,0, 0,0,0,0,                   1,0, 1, 0,0,0,0, 0);
    // two 4-beat rows, tag 1 beat arrives while tag 0 is filling
    add(1,3, 0,0,0,0,                   1,0, 1, 0,0,0,0, 0);
    add(1,3, 0,0,0,0,                   1,1, 1, 0,0,0,0, 1);
    add(0,0, 1,0,64'h200,0,             1,2, 1, 0,0,0,0, 2);
    add(0,0, 1,0,64'h201,0,             1,2, 1, 1,0,3,64'h200, 2);
    add(0,0, 1,1,64'h300,0,             1,2, 0, 1,0,3,64'h201, 2);
    add(0,0, 1,0,64'h202,0,             1,2, 1, 0,0,0,0, 2);
    add(0,0, 1,0,64'h203,0,             1,2, 1, 1,0,3,64'h202, 2);
    add(0,0, 1,1,64'h300,0,             1,2, 0, 1,0,3,64'h203, 2);
    add(0,0, 1,1,64'h300,1,             1,2, 0, 0,0,0,0, 2);
    add(0,0, 1,1,64'h300,0,             1,0, 1, 0,0,0,0, 1);
    add(0,0, 1,1,64'h301,0,             1,0, 1, 1,1,3,64'h300, 1);
    add(0,0, 1,1,64'h302,0,             1,0, 1, 1,1,3,64'h301, 1);
    add(0,0, 1,1,64'h303,0,             1,0, 1, 1,1,3,64'h302, 1);
    add(0,0, 0,0,0,1,                   1,0, 0, 1,1,3,64'h303, 1);
    add(0,0, 0,0,0,0,                   1,0, 1, 0,0,0,0, 0);

    repeat (2) @(negedge CLK);
    do_reset("reset");

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].inum, vecs[i].dv, vecs[i].did, vecs[i].d, vecs[i].lt, 1'b0);
      chk($sformatf("v%0d issue_ready", i), bus.issue_ready, vecs[i].e_ir);
      if (vecs[i].e_ir) chk($sformatf("v%0d issue_id", i), bus.issue_id, vecs[i].e_iid);
      chk($sformatf("v%0d dram_res_ready", i), bus.dram_res_ready, vecs[i].e_dr);
      chk($sformatf("v%0d lat_valid", i), bus.lat_dram_res_valid, vecs[i].e_lv);
      if (vecs[i].e_lv) begin
        chk($sformatf("v%0d lat_id", i), bus.lat_dram_id, vecs[i].e_lid);
        chk($sformatf("v%0d lat_num", i), bus.lat_num_request, vecs[i].e_lnum);
        chk($sformatf("v%0d lat_xbar", i), bus.lat_xbar, mk_xbar(vecs[i].e_lnum));
        chk($sformatf("v%0d lat_data", i), bus.lat_dram_rddata, vecs[i].e_ld);
      end
      chk($sformatf("v%0d outstanding", i), bus.outstanding, vecs[i].e_out);
      chk($sformatf("v%0d err", i), bus.err_unknown_id, 0);
    end

    // fill all sixteen tags, then free tag 5 and reallocate it
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("full issue_ready %0d", i), bus.issue_ready, 1);
      chk($sformatf("full issue_id %0d", i), bus.issue_id, i);
      chk($sformatf("full outstanding %0d", i), bus.outstanding, i);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("full 17th issue_ready", bus.issue_ready, 0);
    chk("full 17th outstanding", bus.outstanding, 16);
    drive(0, 0, 1, 5, 64'h55, 0, 0);
    chk("full dram_res_ready", bus.dram_res_ready, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("full tag5 lat_valid", bus.lat_dram_res_valid, 1);
    chk("full tag5 lat_id", bus.lat_dram_id, 5);
    chk("full tag5 lat_data", bus.lat_dram_rddata, 64'h55);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("full free cycle issue_ready", bus.issue_ready, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("full after free issue_ready", bus.issue_ready, 1);
    chk("full after free issue_id", bus.issue_id, 5);
    chk("full after free outstanding", bus.outstanding, 15);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("full refilled issue_ready", bus.issue_ready, 0);
    chk("full refilled outstanding", bus.outstanding, 16);
    do_reset("reset after full");

    // backend stall for three cycles in the middle of a 4-beat fill
    drive(1, 3, 0, 0, 0, 0, 0);
    chk("stall issue_id", bus.issue_id, 0);
    drive(0, 0, 1, 0, 64'h400, 0, 0);
    chk("stall beat0 ready", bus.dram_res_ready, 1);
    drive(0, 0, 1, 0, 64'h401, 0, 0);
    chk("stall beat1 ready", bus.dram_res_ready, 1);
    for (int s = 0; s < 3; s++) begin
      drive(0, 0, 1, 0, 64'h402, 0, 1);
      chk($sformatf("stall %0d ready", s), bus.dram_res_ready, 0);
      chk($sformatf("stall %0d lat_valid", s), bus.lat_dram_res_valid, (s == 0));
      if (s == 0) chk("stall beat1 lat_data", bus.lat_dram_rddata, 64'h401);
    end
    drive(0, 0, 1, 0, 64'h402, 0, 0);
    chk("resume beat2 ready", bus.dram_res_ready, 1);
    chk("resume lat_valid", bus.lat_dram_res_valid, 0);
    drive(0, 0, 1, 0, 64'h403, 0, 0);
    chk("resume beat3 ready", bus.dram_res_ready, 1);
    chk("resume beat2 lat_data", bus.lat_dram_rddata, 64'h402);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("resume drain ready", bus.dram_res_ready, 0);
    chk("resume beat3 lat_valid", bus.lat_dram_res_valid, 1);
    chk("resume beat3 lat_data", bus.lat_dram_rddata, 64'h403);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("stall row freed", bus.outstanding, 0);

    // unknown id with an empty table
    drive(0, 0, 1, 9, 64'h999, 0, 0);
    chk("unknown ready", bus.dram_res_ready, 1);
    chk("unknown err before", bus.err_unknown_id, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("unknown lat_valid", bus.lat_dram_res_valid, 0);
    chk("unknown err set", bus.err_unknown_id, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("unknown err sticky", bus.err_unknown_id, 1);
    chk("unknown still idle", bus.dram_res_ready, 1);

    // reset in the middle of an 8-beat fill, then a late beat for the old tag
    drive(1, 7, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 64'h500, 0, 0);
    drive(0, 0, 1, 0, 64'h501, 0, 0);
    chk("midfill lat_valid", bus.lat_dram_res_valid, 1);
    do_reset("reset midfill");
    drive(0, 0, 1, 0, 64'h502, 0, 0);
    chk("late beat ready", bus.dram_res_ready, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("late beat lat_valid", bus.lat_dram_res_valid, 0);
    chk("late beat err", bus.err_unknown_id, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
